// File: rtl/limn2600_ram_responder.sv
// Word-addressed RAM responder for the Limn2600 RAM command bus: one command in flight,
// programmable read/write latency, 1-cycle ram_rdy pulse, bus_err on accesses outside the window.
module limn2600_ram_responder #(
   parameter int          DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          READ_LAT    = 2,
   parameter int          WRITE_LAT   = 1,
   parameter              INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ram_ce,
   input  logic        ram_we,
   input  logic [31:0] ram_addr,
   input  logic [31:0] ram_data_out,
   output logic [31:0] ram_data_in,
   output logic        ram_rdy,
   output logic        bus_err,
   output logic        busy
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_TURN} state_t;

   state_t        state;
   logic [3:0]    cnt;
   logic          we_q;
   logic          in_range_q;
   logic [AW-1:0] idx_q;
   logic [31:0]   data_q;

   logic [31:0]   mem [DEPTH_WORDS];

   // Window decode on the live address; only meaningful at acceptance, then latched.
   logic [32:0]   off;
   logic          in_range;
   logic [AW-1:0] idx;
   logic          unused_off;

   assign off        = {1'b0, ram_addr} - {1'b0, BASE_ADDR};
   assign in_range   = !off[32] && ({2'b00, off[31:2]} < 32'(DEPTH_WORDS));
   assign idx        = off[AW+1:2];
   assign unused_off = ^off[1:0];

   logic [3:0] lat;
   assign lat = ram_we ? 4'(WRITE_LAT) : 4'(READ_LAT);

   // Zero-latency commands complete straight from IDLE, so use live fields there.
   logic          cur_we;
   logic          cur_in_range;
   logic [AW-1:0] cur_idx;
   logic [31:0]   cur_data;
   logic          go_resp;

   assign cur_we       = (state == S_IDLE) ? ram_we       : we_q;
   assign cur_in_range = (state == S_IDLE) ? in_range     : in_range_q;
   assign cur_idx      = (state == S_IDLE) ? idx          : idx_q;
   assign cur_data     = (state == S_IDLE) ? ram_data_out : data_q;
   assign go_resp      = ((state == S_IDLE) && ram_ce && (lat == 4'd0)) ||
                         ((state == S_WAIT) && (cnt == 4'd1));

   always_ff @(posedge clk) begin
      if (go_resp && cur_we && cur_in_range)
         mem[cur_idx] <= cur_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         cnt         <= 4'd0;
         ram_rdy     <= 1'b0;
         bus_err     <= 1'b0;
         busy        <= 1'b0;
         ram_data_in <= 32'h0000_0000;
         we_q        <= 1'b0;
         in_range_q  <= 1'b0;
         idx_q       <= '0;
         data_q      <= 32'h0000_0000;
      end else begin
         ram_rdy <= go_resp;
         bus_err <= go_resp && !cur_in_range;
         if (go_resp && !cur_we)
            ram_data_in <= cur_in_range ? mem[cur_idx] : 32'h0000_0000;

         case (state)
            S_IDLE: begin
               if (ram_ce) begin
                  we_q       <= ram_we;
                  in_range_q <= in_range;
                  idx_q      <= idx;
                  data_q     <= ram_data_out;
                  busy       <= 1'b1;
                  cnt        <= lat;
                  state      <= (lat == 4'd0) ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1)
                  state <= S_RESP;
            end
            S_RESP: state <= S_TURN;
            S_TURN: begin
               // Dead cycle: a command still shown after rdy must not run again.
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_limn2600_ram_responder.sv
// Self-checking bench: three responder instances with different windows/latencies, checked against
// a word-level memory model (associative array) and the latency/window rules.
module tb_limn2600_ram_responder;

   logic        clk = 1'b0;
   logic        rst_n [3];
   logic        ce    [3];
   logic        we    [3];
   logic [31:0] addr  [3];
   logic [31:0] wdat  [3];
   logic [31:0] rdata [3];
   logic        rdy   [3];
   logic        err   [3];
   logic        busy  [3];

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem_m [int];
   logic [31:0] last_rd [3];

   always #5 clk = ~clk;

   limn2600_ram_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_1000), .READ_LAT(2), .WRITE_LAT(1)) u0 (
      .clk(clk), .rst(rst_n[0]), .ram_ce(ce[0]), .ram_we(we[0]), .ram_addr(addr[0]),
      .ram_data_out(wdat[0]), .ram_data_in(rdata[0]), .ram_rdy(rdy[0]), .bus_err(err[0]), .busy(busy[0]));

   limn2600_ram_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_0000), .READ_LAT(3), .WRITE_LAT(5)) u1 (
      .clk(clk), .rst(rst_n[1]), .ram_ce(ce[1]), .ram_we(we[1]), .ram_addr(addr[1]),
      .ram_data_out(wdat[1]), .ram_data_in(rdata[1]), .ram_rdy(rdy[1]), .bus_err(err[1]), .busy(busy[1]));

   limn2600_ram_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_0000), .READ_LAT(0), .WRITE_LAT(0)) u2 (
      .clk(clk), .rst(rst_n[2]), .ram_ce(ce[2]), .ram_we(we[2]), .ram_addr(addr[2]),
      .ram_data_out(wdat[2]), .ram_data_in(rdata[2]), .ram_rdy(rdy[2]), .bus_err(err[2]), .busy(busy[2]));

   // ---------------- reference model ----------------
   function automatic logic [31:0] base_of(int u);
      return (u == 0) ? 32'h0000_1000 : 32'h0000_0000;
   endfunction

   function automatic int lat_of(int u, logic w);
      case (u)
         0:       return w ? 1 : 2;
         1:       return w ? 5 : 3;
         default: return 0;
      endcase
   endfunction

   function automatic logic in_win(int u, logic [31:0] a);
      longint off;
      off = longint'(a) - longint'(base_of(u));
      return (off >= 0) && ((off / 4) < 16);
   endfunction

   task automatic model_access(input int u, input logic w, input logic [31:0] a, input logic [31:0] d,
                               output logic [31:0] exp_rd, output logic exp_err);
      int key;
      exp_err = !in_win(u, a);
      key = u * 1000 + int'((a - base_of(u)) / 4);
      if (w) begin
         if (!exp_err) mem_m[key] = d;
      end else begin
         if (exp_err)               last_rd[u] = 32'h0000_0000;
         else if (mem_m.exists(key)) last_rd[u] = mem_m[key];
         else                        last_rd[u] = 32'hDEAD_BEEF;
      end
      exp_rd = last_rd[u];
   endtask

   // ---------------- bus driver ----------------
   // Called at a negedge; returns at the negedge inside the rdy cycle with ce still asserted.
   // edges counts posedges from the call to the rdy cycle; -1 means rdy never came.
   task automatic do_cmd(input int u, input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic er, output int edges);
      logic done;
      ce[u] = 1'b1; we[u] = w; addr[u] = a; wdat[u] = d;
      edges = 0;
      done  = 1'b0;
      while (!done) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (rdy[u] === 1'b1) done = 1'b1;
         else if (edges >= 60) begin edges = -1; done = 1'b1; end
      end
      rd = rdata[u];
      er = err[u];
   endtask

   task automatic finish_cmd(input int u);
      ce[u] = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      for (int u = 0; u < 3; u++) begin
         rst_n[u] = 1'b1; ce[u] = 1'b0; we[u] = 1'b0; addr[u] = '0; wdat[u] = '0; last_rd[u] = '0;
      end
      #2;
      for (int u = 0; u < 3; u++) rst_n[u] = 1'b0;
      #1;
      for (int u = 0; u < 3; u++) begin
         checks++; if (rdy[u] !== 1'b0) begin failures++; $display("FAIL reset_rdy u%0d got %b want 0", u, rdy[u]); end
         checks++; if (err[u] !== 1'b0) begin failures++; $display("FAIL reset_err u%0d got %b want 0", u, err[u]); end
         checks++; if (busy[u] !== 1'b0) begin failures++; $display("FAIL reset_busy u%0d got %b want 0", u, busy[u]); end
         checks++; if (rdata[u] !== 32'h0) begin failures++; $display("FAIL reset_data u%0d got %h want 0", u, rdata[u]); end
      end
      repeat (2) @(negedge clk);
      for (int u = 0; u < 3; u++) rst_n[u] = 1'b1;
      @(negedge clk);
   endtask

   task automatic run_ops(input string name, input int u, input logic ws[], input logic [31:0] as[], input logic [31:0] ds[]);
      logic [31:0] rd, exp_rd;
      logic er, exp_err;
      int e;
      for (int i = 0; i < ws.size(); i++) begin
         do_cmd(u, ws[i], as[i], ds[i], rd, er, e);
         model_access(u, ws[i], as[i], ds[i], exp_rd, exp_err);
         finish_cmd(u);
         checks++; if (e !== lat_of(u, ws[i]) + 1) begin failures++; $display("FAIL %s_lat op%0d got %0d want %0d", name, i, e, lat_of(u, ws[i]) + 1); end
         checks++; if (er !== exp_err) begin failures++; $display("FAIL %s_err op%0d got %b want %b", name, i, er, exp_err); end
         checks++; if (rd !== exp_rd) begin failures++; $display("FAIL %s_data op%0d got %h want %h", name, i, rd, exp_rd); end
      end
   endtask

   task automatic test_write_read;
      run_ops("write_read", 0, '{1'b1, 1'b0}, '{32'h0000_1010, 32'h0000_1010}, '{32'hCAFE_BABE, 32'h0});
   endtask

   task automatic test_held_ce;
      logic [31:0] v, rd, exp_rd;
      logic er, exp_err;
      int e;
      v = $urandom;
      do_cmd(0, 1'b1, 32'h0000_1014, v, rd, er, e);
      model_access(0, 1'b1, 32'h0000_1014, v, exp_rd, exp_err);
      checks++; if (e !== 2) begin failures++; $display("FAIL held_lat got %0d want 2", e); end
      @(negedge clk);
      checks++; if (rdy[0] !== 1'b0) begin failures++; $display("FAIL held_rdy_pulse got %b want 0", rdy[0]); end
      checks++; if (busy[0] !== 1'b1) begin failures++; $display("FAIL held_busy_turn got %b want 1", busy[0]); end
      @(negedge clk);
      checks++; if (busy[0] !== 1'b0 || rdy[0] !== 1'b0) begin failures++; $display("FAIL held_reaccept busy=%b rdy=%b want 0 0", busy[0], rdy[0]); end
      ce[0] = 1'b0;
      @(negedge clk);
      checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL held_idle got %b want 0", busy[0]); end
      run_ops("held_rb", 0, '{1'b0}, '{32'h0000_1014}, '{32'h0});
   endtask

   task automatic test_out_of_range;
      run_ops("oor", 0,
              '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0},
              '{32'h1000, 32'h1000, 32'h0FFC, 32'h1040, 32'h1000, 32'h103C, 32'h103C},
              '{32'h1234_5678, 32'h0, 32'h0, 32'hBAD0_BAD0, 32'h0, 32'h0BAD_F00D, 32'h0});
   endtask

   task automatic test_align_wrap;
      logic [31:0] v1, v2, v3;
      v1 = $urandom; v2 = $urandom; v3 = $urandom;
      run_ops("align", 0,
              '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
              '{32'h1013, 32'h1010, 32'h1000, 32'h103C, 32'h1000, 32'h103C},
              '{v1, 32'h0, v2, v3, 32'h0, 32'h0});
   endtask

   task automatic test_reset_mid_write;
      logic [31:0] va;
      va = $urandom | 32'h1;
      run_ops("rst_pre", 1, '{1'b1, 1'b0}, '{32'h8, 32'h8}, '{va, 32'h0});
      ce[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h8; wdat[1] = ~va;
      @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      rst_n[1] = 1'b0;
      ce[1] = 1'b0;
      last_rd[1] = 32'h0;
      #1;
      checks++; if (busy[1] !== 1'b0) begin failures++; $display("FAIL rst_busy got %b want 0", busy[1]); end
      checks++; if (rdy[1] !== 1'b0) begin failures++; $display("FAIL rst_rdy got %b want 0", rdy[1]); end
      checks++; if (err[1] !== 1'b0) begin failures++; $display("FAIL rst_err got %b want 0", err[1]); end
      checks++; if (rdata[1] !== 32'h0) begin failures++; $display("FAIL rst_data got %h want 0", rdata[1]); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (rdy[1] !== 1'b0) begin failures++; $display("FAIL rst_no_rdy cyc%0d got %b want 0", i, rdy[1]); end
      end
      rst_n[1] = 1'b1;
      run_ops("rst_post", 1, '{1'b0}, '{32'h8}, '{32'h0});
   endtask

   task automatic test_zero_latency;
      logic [31:0] a, d, rd, exp_rd;
      logic w, er, exp_err;
      int e;
      for (int i = 0; i < 116; i++) begin
         if (i < 16) begin
            w = 1'b1; a = 32'(i * 4);
         end else begin
            w = 1'($urandom_range(0, 1)); a = 32'($urandom_range(0, 'h4F));
         end
         d = $urandom;
         do_cmd(2, w, a, d, rd, er, e);
         model_access(2, w, a, d, exp_rd, exp_err);
         checks++; if (e !== ((i == 0) ? 1 : 3)) begin failures++; $display("FAIL zl_period op%0d got %0d want %0d", i, e, (i == 0) ? 1 : 3); end
         checks++; if (er !== exp_err) begin failures++; $display("FAIL zl_err op%0d addr %h got %b want %b", i, a, er, exp_err); end
         checks++; if (rd !== exp_rd) begin failures++; $display("FAIL zl_data op%0d addr %h got %h want %h", i, a, rd, exp_rd); end
      end
      finish_cmd(2);
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_held_ce;
      test_out_of_range;
      test_align_wrap;
      test_reset_mid_write;
      test_zero_latency;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
